// File: rtl/cache_0_tag_ctrl.sv
// cache_0_tag_ctrl
//   Lookup/allocate controller for the cache 0 tag RAM. It accepts one CPU
//   request at a time. For each request it reads the tag RAM, compares the
//   tag, responds hit/miss, and writes back the updated tag word. On a miss
//   it allocates the line with the new tag. A miss that displaces a valid
//   dirty line is reported as an eviction. A store hit marks the line dirty.
//
//   Tag RAM word layout: {valid, dirty, tag[TAG_W-1:0]}.
//   The RAM returns read data one cycle after the address is presented.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   req_valid/ready     request handshake (see below)
//   req_addr            {tag, index} of the request
//   req_write           1 = store, 0 = load
//   resp_valid          one-cycle response strobe (no back-pressure)
//   resp_hit            lookup hit
//   resp_evict          miss displaced a valid dirty line
//   resp_evict_addr     {victim tag, index}; meaningful when resp_evict=1
//   tag_addr/wdata/we   tag RAM address, write data, write enable
//   tag_rdata           tag RAM read data
//   dbg_state           current controller state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. req_ready is high only in IDLE. The requester
//   holds req_addr and req_write stable until that edge. resp_valid is a
//   single-cycle pulse that the consumer must take.
module cache_0_tag_ctrl #(
    parameter int AWIDTH         = 3,
    parameter int TAG_W          = 12,
    parameter int DWIDTH         = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [TAG_W+AWIDTH-1:0] req_addr,
    input  logic                    req_write,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic                    resp_evict,
    output logic [TAG_W+AWIDTH-1:0] resp_evict_addr,
    output logic [AWIDTH-1:0]       tag_addr,
    output logic [DWIDTH-1:0]       tag_wdata,
    output logic                    tag_we,
    input  logic [DWIDTH-1:0]       tag_rdata,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                    state_q;
    logic [AWIDTH-1:0]         cnt_q;
    logic [AWIDTH-1:0]         idx_q;
    logic [TAG_W-1:0]          tag_q;
    logic                      write_q;
    logic                      resp_valid_q;
    logic                      resp_hit_q;
    logic                      resp_evict_q;
    logic [TAG_W+AWIDTH-1:0]   resp_evict_addr_q;

    // Fields of the entry returned by the RAM during READ.
    logic                      rd_valid;
    logic                      rd_dirty;
    logic [TAG_W-1:0]          rd_tag;
    logic                      hit;

    assign rd_valid = tag_rdata[DWIDTH-1];
    assign rd_dirty = tag_rdata[DWIDTH-2];
    assign rd_tag   = tag_rdata[TAG_W-1:0];
    assign hit      = rd_valid && (rd_tag == tag_q);

    // RAM-side and ready outputs are decoded from state. They cannot be
    // registered because the READ-cycle write depends on the read data
    // that arrives in that same cycle. Gating with reset_n forces them low
    // the instant reset is asserted, whatever state the register reset
    // leaves the controller in.
    always_comb begin
        req_ready = 1'b0;
        tag_we    = 1'b0;
        tag_wdata = '0;
        tag_addr  = idx_q;
        case (state_q)
            ST_INIT: begin
                tag_we   = reset_n;
                tag_addr = cnt_q;
            end
            ST_IDLE: begin
                req_ready = reset_n;
                tag_addr  = req_addr[AWIDTH-1:0];
            end
            ST_READ: begin
                // A load hit leaves the entry untouched. Every other case
                // writes {1, write, tag}: a store hit sets dirty, and a
                // miss allocates with dirty = store.
                tag_we    = reset_n & ~(hit & ~write_q);
                tag_wdata = {1'b1, write_q, tag_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_IDLE;
            end
            cnt_q             <= '0;
            idx_q             <= '0;
            tag_q             <= '0;
            write_q           <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_hit_q        <= 1'b0;
            resp_evict_q      <= 1'b0;
            resp_evict_addr_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // All-ones counter means the last entry is being written.
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        tag_q   <= req_addr[TAG_W+AWIDTH-1:AWIDTH];
                        idx_q   <= req_addr[AWIDTH-1:0];
                        write_q <= req_write;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    resp_valid_q      <= 1'b1;
                    resp_hit_q        <= hit;
                    resp_evict_q      <= ~hit & rd_valid & rd_dirty;
                    resp_evict_addr_q <= {rd_tag, idx_q};
                    state_q           <= ST_RESP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_hit        = resp_hit_q;
    assign resp_evict      = resp_evict_q;
    assign resp_evict_addr = resp_evict_addr_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_cache_0_tag_ctrl.sv
// tb_cache_0_tag_ctrl
//   Bench for cache_0_tag_ctrl. It contains a behavioural tag RAM with a
//   one-cycle read latency, a table of directed lookups, and randomized
//   lookups. The randomized lookups are checked against a per-index
//   {valid, dirty, tag} model held in plain arrays. The bench also checks
//   the reset sweep and a reset asserted in the middle of a lookup.
module tb_cache_0_tag_ctrl;

    localparam int AW    = 3;
    localparam int TW    = 12;
    localparam int DW    = 14;
    localparam int RA    = TW + AW;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset / DUT ----------------
    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [RA-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic          resp_valid;
    logic          resp_hit;
    logic          resp_evict;
    logic [RA-1:0] resp_evict_addr;
    logic [AW-1:0] tag_addr;
    logic [DW-1:0] tag_wdata;
    logic          tag_we;
    logic [DW-1:0] tag_rdata;
    logic [1:0]    dbg_state;

    always #5 clock = ~clock;

    cache_0_tag_ctrl dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_write       (req_write),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_evict      (resp_evict),
        .resp_evict_addr (resp_evict_addr),
        .tag_addr        (tag_addr),
        .tag_wdata       (tag_wdata),
        .tag_we          (tag_we),
        .tag_rdata       (tag_rdata),
        .dbg_state       (dbg_state)
    );

    // Tag RAM: synchronous write, read data one cycle after the address.
    // The bench-side port fills the RAM with junk before the sweep.
    logic [DW-1:0] ram [DEPTH];
    logic          tb_wr = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;

    always @(posedge clock) begin
        if (tb_wr) begin
            ram[tb_waddr] <= tb_wdata;
        end else if (tag_we) begin
            ram[tag_addr] <= tag_wdata;
        end
        tag_rdata <= ram[tag_addr];
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    // Expected response {hit, evict, evict_addr}.
    logic [RA+1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_valid [DEPTH];
    bit            m_dirty [DEPTH];
    logic [TW-1:0] m_tag   [DEPTH];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    // Applies one access to the model and returns what the cache should report.
    task automatic model_access(input logic [RA-1:0] addr, input logic wr,
                                output logic hit, output logic ev,
                                output logic [RA-1:0] ev_addr, output logic [DW-1:0] word);
        int            idx;
        logic [TW-1:0] t;
        idx     = int'(addr[AW-1:0]);
        t       = addr[RA-1:AW];
        hit     = m_valid[idx] && (m_tag[idx] == t);
        ev      = !hit && m_valid[idx] && m_dirty[idx];
        ev_addr = {m_tag[idx], addr[AW-1:0]};
        if (hit) begin
            m_dirty[idx] = m_dirty[idx] | wr;
        end else begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = wr;
            m_tag[idx]   = t;
        end
        word = {m_valid[idx], m_dirty[idx], m_tag[idx]};
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with reset_n low. Releases reset and checks
    // the DEPTH-cycle clearing sweep, then the return to ready.
    task automatic sweep_check();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check($sformatf("sweep_we[%0d]", i), tag_we, 1);
            check($sformatf("sweep_addr[%0d]", i), tag_addr, i);
            check($sformatf("sweep_wdata[%0d]", i), tag_wdata, 0);
            check($sformatf("sweep_ready[%0d]", i), req_ready, 0);
            @(negedge clock);
        end
        #1;
        check("after_sweep_ready", req_ready, 1);
        check("after_sweep_we", tag_we, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ram_cleared[%0d]", i), ram[i], 0);
        end
    endtask

    // Called just after a falling edge. Performs one request and returns the
    // response, checking latency, the pulse width and the RESP-cycle outputs.
    task automatic run_req(input logic [RA-1:0] addr, input logic wr,
                           output logic hit, output logic ev, output logic [RA-1:0] ev_addr);
        int waitc;
        int lat;
        hit     = 1'b0;
        ev      = 1'b0;
        ev_addr = '0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        #1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clock);
            #1;
            waitc++;
        end
        if (!req_ready) begin
            check("accept_timeout", 1, 0);
            req_valid = 1'b0;
            return;
        end
        @(negedge clock);
        // The handshake is done; scramble the request bus to show it is not reused.
        req_valid = 1'b0;
        req_addr  = RA'($urandom);
        req_write = 1'($urandom);
        #1;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clock);
            #1;
            lat++;
        end
        check("resp_latency", lat, 2);
        hit     = resp_hit;
        ev      = resp_evict;
        ev_addr = resp_evict_addr;
        check("resp_ready_low", req_ready, 0);
        check("resp_we_low", tag_we, 0);
        @(negedge clock);
        #1;
        check("resp_pulse_width", resp_valid, 0);
        check("resp_hit_hold", resp_hit, hit);
        check("idle_we_low", tag_we, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [RA-1:0] addr;
        logic          wr;
        logic          hit;
        logic          ev;
        logic [RA-1:0] ev_addr;
        logic [DW-1:0] word;
    } vec_t;

    vec_t vecs[8];

    // ---------------- main sequence ----------------
    initial begin
        logic          g_hit, g_ev, m_hit, m_ev;
        logic [RA-1:0] g_ev_addr, m_ev_addr;
        logic [DW-1:0] m_word;
        logic [RA+1:0] exp_r;
        logic [RA-1:0] a;
        logic          w;

        vecs[0] = '{{12'hABC, 3'd5}, 1'b0, 1'b0, 1'b0, 15'd0, 14'h2ABC};
        vecs[1] = '{{12'hABC, 3'd5}, 1'b0, 1'b1, 1'b0, 15'd0, 14'h2ABC};
        vecs[2] = '{{12'hABC, 3'd5}, 1'b1, 1'b1, 1'b0, 15'd0, 14'h3ABC};
        vecs[3] = '{{12'h123, 3'd5}, 1'b0, 1'b0, 1'b1, {12'hABC, 3'd5}, 14'h2123};
        vecs[4] = '{{12'h00F, 3'd2}, 1'b0, 1'b0, 1'b0, 15'd0, 14'h200F};
        vecs[5] = '{{12'h0AA, 3'd2}, 1'b0, 1'b0, 1'b0, 15'd0, 14'h20AA};
        vecs[6] = '{{12'h0AA, 3'd2}, 1'b1, 1'b1, 1'b0, 15'd0, 14'h30AA};
        vecs[7] = '{{12'h123, 3'd5}, 1'b1, 1'b1, 1'b0, 15'd0, 14'h3123};

        // Fill the RAM with non-zero junk while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            tb_wr    = 1'b1;
            tb_waddr = AW'(i);
            tb_wdata = DW'($urandom) | DW'(1);
        end
        @(negedge clock);
        tb_wr = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_evict", resp_evict, 0);
        check("rst_evict_addr", resp_evict_addr, 0);
        check("rst_we", tag_we, 0);
        check("rst_wdata", tag_wdata, 0);

        model_clear();
        sweep_check();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            model_access(vecs[i].addr, vecs[i].wr, m_hit, m_ev, m_ev_addr, m_word);
            run_req(vecs[i].addr, vecs[i].wr, g_hit, g_ev, g_ev_addr);
            check($sformatf("vec%0d_hit", i), g_hit, vecs[i].hit);
            check($sformatf("vec%0d_evict", i), g_ev, vecs[i].ev);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_evict_addr", i), g_ev_addr, vecs[i].ev_addr);
            end
            check($sformatf("vec%0d_ram", i), ram[vecs[i].addr[AW-1:0]], vecs[i].word);
        end

        // Randomized requests: a small tag pool so hits, dirty evictions and
        // back-to-back same-index lookups all occur.
        for (int n = 0; n < 80; n++) begin
            a = {12'hA00 | TW'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH - 1))};
            w = 1'($urandom_range(0, 1));
            model_access(a, w, m_hit, m_ev, m_ev_addr, m_word);
            exp_q.push_back({m_hit, m_ev, m_ev_addr});
            run_req(a, w, g_hit, g_ev, g_ev_addr);
            exp_r = exp_q.pop_front();
            check("rand_hit", g_hit, exp_r[RA+1]);
            check("rand_evict", g_ev, exp_r[RA]);
            if (exp_r[RA]) begin
                check("rand_evict_addr", g_ev_addr, exp_r[RA-1:0]);
            end
            check("rand_ram", ram[a[AW-1:0]], m_word);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // Reset asserted while a lookup is in READ: the request is dropped.
        req_valid = 1'b1;
        req_addr  = {12'h5A5, 3'd4};
        req_write = 1'b1;
        #1;
        check("pre_reset_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_resp_hit", resp_hit, 0);
        check("midrst_resp_evict", resp_evict, 0);
        check("midrst_evict_addr", resp_evict_addr, 0);
        check("midrst_we", tag_we, 0);
        check("midrst_wdata", tag_wdata, 0);
        check("midrst_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("midrst_no_resp", resp_valid, 0);
        end
        model_clear();
        sweep_check();

        // Normal operation after the re-run sweep.
        model_access({12'hABC, 3'd5}, 1'b0, m_hit, m_ev, m_ev_addr, m_word);
        run_req({12'hABC, 3'd5}, 1'b0, g_hit, g_ev, g_ev_addr);
        check("post_rst_hit", g_hit, 0);
        check("post_rst_evict", g_ev, 0);
        check("post_rst_ram", ram[5], 14'h2ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Overall time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
